sc_pointbcd: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the point counter. It watches the counter's binary output bus and, whenever the value changes, runs an iterative shift-add-3 (double-dabble) conversion. It then presents the decimal digits, held stable, to the seven-segment display decoders. One shift per clock keeps the logic small; the display only needs a result within a few cycles of a score change.

---
 rtl/sc_pointbcd_pkg.sv | 19 +
 rtl/sc_bcd_add3.sv | 17 +
 rtl/sc_pointbcd.sv | 108 ++++++++++
 tb/tb_sc_pointbcd.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sc_pointbcd_pkg.sv
// Shared constants and FSM encoding for the point-counter BCD converter.
package sc_pointbcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    // Digits at or above this value get +3 before each shift
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_CONVERT = 2'd1;
    localparam logic [1:0] STATE_LATCH   = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = STATE_IDLE,
        StConvert = STATE_CONVERT,
        StLatch   = STATE_LATCH
    } pointbcd_state_e;

endpackage

// File: rtl/sc_bcd_add3.sv
// Single-digit double-dabble corrector: adds 3 to a BCD digit of 5 or more.
module sc_bcd_add3
    import sc_pointbcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Pre-shift correction so the following doubling carries into the next digit
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESHOLD) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/sc_pointbcd.sv
// Iterative binary-to-BCD converter watching the point counter output.
// One shift per clock; results are latched only once complete.
module sc_pointbcd
    import sc_pointbcd_pkg::*;
#(
    parameter int unsigned POINTBCD_DATAWIDTH = 8,
    parameter int unsigned POINTBCD_DIGITS    = 3
) (
    input  logic                                   SC_POINTBCD_CLOCK_50,
    input  logic                                   SC_POINTBCD_RESET_InHigh,
    input  logic [POINTBCD_DATAWIDTH-1:0]          SC_POINTBCD_data_InBUS,
    output logic [BCD_DIGIT_W*POINTBCD_DIGITS-1:0] SC_POINTBCD_bcd_OutBUS,
    output logic                                   SC_POINTBCD_valid_Out,
    output logic                                   SC_POINTBCD_done_OutLow
);

    localparam int unsigned BcdW = BCD_DIGIT_W * POINTBCD_DIGITS;
    localparam int unsigned CntW = $clog2(POINTBCD_DATAWIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(POINTBCD_DATAWIDTH - 1);

    pointbcd_state_e                state_q, state_d;
    logic [POINTBCD_DATAWIDTH-1:0]  last_q, last_d;
    logic [POINTBCD_DATAWIDTH-1:0]  shift_q, shift_d;
    logic [BcdW-1:0]                scratch_q, scratch_d;
    logic [BcdW-1:0]                scratch_corr;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic                           force_q, force_d;
    logic [BcdW-1:0]                bcd_q, bcd_d;
    logic                           valid_q, valid_d;
    logic                           done_q, done_d;

    for (genvar g = 0; g < POINTBCD_DIGITS; g++) begin : g_add3
        sc_bcd_add3 u_add3 (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (scratch_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Next-state: capture on change, shift-add-3 per cycle, then publish result
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        force_d   = force_q;
        bcd_d     = bcd_q;
        valid_d   = valid_q;
        done_d    = 1'b1;
        unique case (state_q)
            StIdle: begin
                if ((SC_POINTBCD_data_InBUS != last_q) || force_q) begin
                    shift_d   = SC_POINTBCD_data_InBUS;
                    last_d    = SC_POINTBCD_data_InBUS;
                    scratch_d = '0;
                    cnt_d     = '0;
                    force_d   = 1'b0;
                    valid_d   = 1'b0;
                    state_d   = StConvert;
                end
            end
            StConvert: begin
                {scratch_d, shift_d} = {scratch_corr, shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                bcd_d   = scratch_q;
                valid_d = 1'b1;
                done_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight
    always_ff @(posedge SC_POINTBCD_CLOCK_50) begin
        if (SC_POINTBCD_RESET_InHigh) begin
            state_q   <= StIdle;
            last_q    <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            force_q   <= 1'b1;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            force_q   <= force_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign SC_POINTBCD_bcd_OutBUS  = bcd_q;
    assign SC_POINTBCD_valid_Out   = valid_q;
    assign SC_POINTBCD_done_OutLow = done_q;

endmodule

// File: tb/tb_sc_pointbcd.sv
// Directed bench for sc_pointbcd with default parameters.
module tb_sc_pointbcd;

    logic        clk;
    logic        rst;
    logic [7:0]  data;
    logic [11:0] bcd;
    logic        valid;
    logic        done_n;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int done_ref;

    sc_pointbcd #(
        .POINTBCD_DATAWIDTH (8),
        .POINTBCD_DIGITS    (3)
    ) dut (
        .SC_POINTBCD_CLOCK_50     (clk),
        .SC_POINTBCD_RESET_InHigh (rst),
        .SC_POINTBCD_data_InBUS   (data),
        .SC_POINTBCD_bcd_OutBUS   (bcd),
        .SC_POINTBCD_valid_Out    (valid),
        .SC_POINTBCD_done_OutLow  (done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One count per low done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (done_n === 1'b0) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive val before edge N, verify hold window N..N+8, result at N+9, done release at N+10
    task automatic run_conv(input logic [7:0] val, input logic [11:0] exp,
                            input logic [11:0] prev, input string tag);
        data = val;
        for (int i = 0; i < 9; i++) begin
            tick();
            check({tag, " valid_low"}, {31'd0, valid}, 32'd0);
            check({tag, " bcd_hold"}, {20'd0, bcd}, {20'd0, prev});
            check({tag, " done_high"}, {31'd0, done_n}, 32'd1);
        end
        tick();
        check({tag, " bcd"}, {20'd0, bcd}, {20'd0, exp});
        check({tag, " valid"}, {31'd0, valid}, 32'd1);
        check({tag, " done_low"}, {31'd0, done_n}, 32'd0);
        tick();
        check({tag, " done_end"}, {31'd0, done_n}, 32'd1);
        check({tag, " valid_kept"}, {31'd0, valid}, 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        data = 8'd0;
        tick(); tick(); tick();
        check("rst bcd", {20'd0, bcd}, 32'd0);
        check("rst valid", {31'd0, valid}, 32'd0);
        check("rst done", {31'd0, done_n}, 32'd1);
        rst = 1'b0;

        // Force flag converts 0 after release
        done_ref = done_cnt;
        run_conv(8'd0, 12'h000, 12'h000, "init0");
        tick(); tick();
        check("init0 one_pulse", done_cnt - done_ref, 32'd1);

        run_conv(8'd255, 12'h255, 12'h000, "c255");
        run_conv(8'd99,  12'h099, 12'h255, "c99");
        run_conv(8'd100, 12'h100, 12'h099, "c100");
        run_conv(8'd255, 12'h255, 12'h100, "c255b");
        run_conv(8'd0,   12'h000, 12'h255, "wrap0");

        // Change during conversion: finish 37, then convert 200
        done_ref = done_cnt;
        data = 8'd37;
        tick();                      // N: capture
        tick(); tick(); tick();      // N+3
        data = 8'd200;
        for (int i = 0; i < 5; i++) tick();  // N+8
        check("mid valid_low", {31'd0, valid}, 32'd0);
        tick();                      // N+9
        check("mid bcd37", {20'd0, bcd}, 32'h037);
        check("mid valid37", {31'd0, valid}, 32'd1);
        check("mid done37", {31'd0, done_n}, 32'd0);
        tick();                      // N+10: recapture
        check("mid recapture", {31'd0, valid}, 32'd0);
        check("mid hold37", {20'd0, bcd}, 32'h037);
        for (int i = 0; i < 8; i++) tick();  // N+18
        check("mid valid_low2", {31'd0, valid}, 32'd0);
        tick();                      // N+19
        check("mid bcd200", {20'd0, bcd}, 32'h200);
        check("mid valid200", {31'd0, valid}, 32'd1);
        tick();
        check("mid two_pulses", done_cnt - done_ref, 32'd2);

        // Reset in the middle of converting 150
        data = 8'd150;
        tick();                      // N
        tick(); tick(); tick();      // N+3
        rst = 1'b1;
        tick();                      // N+4
        check("abort bcd", {20'd0, bcd}, 32'd0);
        check("abort valid", {31'd0, valid}, 32'd0);
        check("abort done", {31'd0, done_n}, 32'd1);
        rst = 1'b0;
        run_conv(8'd150, 12'h150, 12'h000, "reconv150");

        // Glitch that returns to the captured value must not retrigger
        done_ref = done_cnt;
        data = 8'd77;
        tick(); tick(); tick();
        data = 8'd80;
        tick(); tick();
        data = 8'd77;
        for (int i = 0; i < 10; i++) tick();
        check("glitch bcd", {20'd0, bcd}, 32'h077);
        check("glitch valid", {31'd0, valid}, 32'd1);
        check("glitch one_pulse", done_cnt - done_ref, 32'd1);

        // Steady input: no further activity
        run_conv(8'd42, 12'h042, 12'h077, "c42");
        done_ref = done_cnt;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("hold valid", {31'd0, valid}, 32'd1);
            check("hold bcd", {20'd0, bcd}, 32'h042);
        end
        check("hold no_pulse", done_cnt - done_ref, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
